irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 status  input  status_t (6)  current status register value (alu_status[3:0], imask, mode).
REQ-004 irq  input  1  level interrupt request; held by source until serviced.
REQ-005 swi  input  1  software-interrupt request, one-cycle pulse.
REQ-006 rti  input  1  return-from-interrupt request, one-cycle pulse.
REQ-007 ready  input  1  core at instruction boundary; entry permitted only when high.
REQ-008 mode_in  output  cpu_mode_e  mode value for status register; constant SUPERVISOR.
REQ-009 ld_mode  output  1  status register mode load strobe.
REQ-010 imask_in  output  1  imask value for status register; constant 1 (masked).
REQ-011 ld_imask  output  1  status register imask load strobe.
REQ-012 status_out  output  6  restore data driven to status register `in` port.
REQ-013 ld_status  output  1  status register full-load strobe.
REQ-014 saved_status  output  status_t  shadow copy of status taken at entry.
REQ-015 saved_valid  output  1  shadow holds an unreturned frame.
REQ-016 vector_req  output  1  one-cycle pulse requesting the core to vector.
REQ-017 cause  output  2  entry cause: 2'b01 irq, 2'b10 swi, 2'b00 none; valid while vector_req=1.
REQ-018 busy  output  1  high whenever FSM is not IDLE.
REQ-019 fault  output  1  one-cycle pulse on illegal rti or swi.

Function
REQ-020 FSM states SHALL be IDLE, SAVE, ENTER, ACK, RESTORE; all strobes are Moore outputs of state.
REQ-021 IDLE: rti=1 SHALL take priority over all entry requests in the same cycle.
REQ-022 IDLE, rti=1, saved_valid=1, status.mode=SUPERVISOR -> RESTORE next cycle.
REQ-023 IDLE, rti=1 with saved_valid=0 or status.mode=USER -> fault=1 for one cycle, stay IDLE, no strobes.
REQ-024 IDLE, ready=1, rti=0, saved_valid=0: swi=1 -> SAVE with cause latched 2'b10; else irq=1 and status.imask=0 -> SAVE with cause 2'b01; swi has priority over irq.
REQ-025 IDLE, swi=1, rti=0, saved_valid=1 -> fault=1 for one cycle, no entry (no nesting).
REQ-026 irq while saved_valid=1, imask=1, or ready=0 SHALL NOT be taken and SHALL remain pending by its level; no fault.
REQ-027 SAVE (1 cycle): saved_status <= status, saved_valid <= 1 -> ENTER.
REQ-028 ENTER (1 cycle): ld_mode=1, ld_imask=1 -> ACK; status register reads SUPERVISOR, imask=1 one edge later.
REQ-029 ACK (1 cycle): vector_req=1 with latched cause -> IDLE; cause cleared to 2'b00 on IDLE entry.
REQ-030 Entry latency: request sampled at edge N -> vector_req high in cycle N+3; busy high cycles N+1..N+3.
REQ-031 RESTORE (1 cycle): status_out=saved_status, ld_status=1, saved_valid <= 0 -> IDLE; status_out=6'b0 in all other states.
REQ-032 swi, rti, irq, ready SHALL be ignored in non-IDLE states; dropped pulses produce no fault.
REQ-033 At most one of ld_mode/ld_imask pair, ld_status, vector_req, fault SHALL be active in any cycle.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, saved_status=6'b0, saved_valid=0, cause=2'b00, all strobes and busy and fault 0.
REQ-035 rst asserted mid-sequence (SAVE/ENTER/ACK/RESTORE) SHALL abort with no further strobes; sequence not resumed after release.
REQ-036 First request after rst release is evaluated at the first rising edge with rst=0.

Verification
REQ-037 status=6'b000000 (USER, imask=0, alu=0), ready=1, irq=1 -> SAVE, ENTER (ld_mode=ld_imask=1), ACK vector_req=1 cause=01 at N+3; saved_status=6'b000000, saved_valid=1.
REQ-038 After REQ-037 entry (status now SUPERVISOR, imask=1, alu=4'b1010), rti pulse -> RESTORE: ld_status=1, status_out=6'b000000, saved_valid=0.
REQ-039 irq=1 and swi=1 same cycle, imask=0 -> cause=10; then irq with imask=1 -> no entry over 10 cycles, no fault.
REQ-040 rti with saved_valid=0 -> fault one cycle, no ld_status; rti in USER with saved_valid=1 -> fault, saved_valid stays 1.
REQ-041 swi while saved_valid=1 -> fault one cycle; rti and swi same cycle with valid frame -> RESTORE only.
REQ-042 rst pulse during ENTER -> all outputs zero immediately, saved_valid=0, no vector_req thereafter until a new request.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt entry/return sequencer: shadows the status register on entry,
// forces supervisor mode with interrupts masked, and restores the shadow on rti.
package irq_ctrl_pkg;
    typedef enum logic {USER = 1'b0, SUPERVISOR = 1'b1} cpu_mode_e;

    typedef struct packed {
        logic [3:0] alu_status;
        logic       imask;
        cpu_mode_e  mode;
    } status_t;
endpackage

module irq_ctrl
    import irq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  status_t    status,
    input  logic       irq,
    input  logic       swi,
    input  logic       rti,
    input  logic       ready,
    output cpu_mode_e  mode_in,
    output logic       ld_mode,
    output logic       imask_in,
    output logic       ld_imask,
    output logic [5:0] status_out,
    output logic       ld_status,
    output status_t    saved_status,
    output logic       saved_valid,
    output logic       vector_req,
    output logic [1:0] cause,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {IDLE, SAVE, ENTER, ACK, RESTORE} state_e;

    state_e     state;
    state_e     state_next;
    logic [1:0] cause_next;
    logic       fault_next;

    assign mode_in  = SUPERVISOR;
    assign imask_in = 1'b1;

    // In IDLE, rti outranks every entry request; illegal rti/swi only raise fault.
    always_comb begin
        state_next = state;
        cause_next = cause;
        fault_next = 1'b0;
        ld_mode    = 1'b0;
        ld_imask   = 1'b0;
        ld_status  = 1'b0;
        vector_req = 1'b0;
        status_out = 6'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (rti) begin
                    if (saved_valid && status.mode == SUPERVISOR)
                        state_next = RESTORE;
                    else
                        fault_next = 1'b1;
                end else if (swi && saved_valid) begin
                    fault_next = 1'b1;
                end else if (ready && !saved_valid) begin
                    if (swi) begin
                        state_next = SAVE;
                        cause_next = 2'b10;
                    end else if (irq && !status.imask) begin
                        state_next = SAVE;
                        cause_next = 2'b01;
                    end
                end
            end
            SAVE: begin
                state_next = ENTER;
            end
            ENTER: begin
                ld_mode    = 1'b1;
                ld_imask   = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                vector_req = 1'b1;
                cause_next = 2'b00;
                state_next = IDLE;
            end
            RESTORE: begin
                ld_status  = 1'b1;
                status_out = saved_status;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fault is registered so it appears as a clean pulse while the FSM stays idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            saved_status <= '0;
            saved_valid  <= 1'b0;
            cause        <= 2'b00;
            fault        <= 1'b0;
        end else begin
            state <= state_next;
            cause <= cause_next;
            fault <= fault_next;
            if (state == SAVE) begin
                saved_status <= status;
                saved_valid  <= 1'b1;
            end else if (state == RESTORE) begin
                saved_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenario tasks followed by a randomized run
// against a queue-based transaction model of entry/return sequences.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    status_t    status;
    logic       irq, swi, rti, ready;
    cpu_mode_e  mode_in;
    logic       ld_mode, imask_in, ld_imask;
    logic [5:0] status_out;
    logic       ld_status;
    status_t    saved_status;
    logic       saved_valid, vector_req;
    logic [1:0] cause;
    logic       busy, fault;

    int vectors     = 0;
    int miscompares = 0;

    irq_ctrl dut (
        .clk(clk), .rst(rst), .status(status), .irq(irq), .swi(swi), .rti(rti),
        .ready(ready), .mode_in(mode_in), .ld_mode(ld_mode), .imask_in(imask_in),
        .ld_imask(ld_imask), .status_out(status_out), .ld_status(ld_status),
        .saved_status(saved_status), .saved_valid(saved_valid),
        .vector_req(vector_req), .cause(cause), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        irq = 1'b0; swi = 1'b0; rti = 1'b0; ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        status = status_t'(6'b0);
        cyc();
        cyc();
        vectors++;
        if ({busy, vector_req, ld_mode, ld_imask, ld_status, fault, saved_valid} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got %b expected 0000000",
                     {busy, vector_req, ld_mode, ld_imask, ld_status, fault, saved_valid});
        end
        vectors++;
        if ({saved_status, cause, status_out} !== 14'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %b expected 0", {saved_status, cause, status_out});
        end
        vectors++;
        if ({mode_in, imask_in} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL const_outputs: got %b expected 11", {mode_in, imask_in});
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_irq_entry();
        status = status_t'(6'b0);
        irq = 1'b1;
        ready = 1'b1;
        cyc();
        vectors++;
        if ({busy, vector_req, ld_mode} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL entry_save: got %b expected 100", {busy, vector_req, ld_mode});
        end
        cyc();
        vectors++;
        if ({busy, ld_mode, ld_imask, vector_req} !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL entry_enter: got %b expected 1110", {busy, ld_mode, ld_imask, vector_req});
        end
        vectors++;
        if ({saved_valid, saved_status} !== 7'b1000000) begin
            miscompares++;
            $display("[TB] FAIL entry_shadow: got %b expected 1000000", {saved_valid, saved_status});
        end
        status = status_t'(6'b101011);
        cyc();
        vectors++;
        if ({busy, vector_req, cause} !== 4'b1101) begin
            miscompares++;
            $display("[TB] FAIL entry_ack: got %b expected 1101", {busy, vector_req, cause});
        end
        irq = 1'b0;
        cyc();
        vectors++;
        if ({busy, vector_req, cause, saved_valid} !== 5'b00001) begin
            miscompares++;
            $display("[TB] FAIL entry_idle: got %b expected 00001", {busy, vector_req, cause, saved_valid});
        end
    endtask

    task automatic test_rti_restore();
        rti = 1'b1;
        cyc();
        rti = 1'b0;
        vectors++;
        if ({busy, ld_status, ld_mode, fault, status_out} !== 10'b1100_000000) begin
            miscompares++;
            $display("[TB] FAIL restore: got %b expected 1100000000",
                     {busy, ld_status, ld_mode, fault, status_out});
        end
        status = status_t'(6'b0);
        cyc();
        vectors++;
        if ({busy, ld_status, saved_valid, fault} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL restore_idle: got %b expected 0000", {busy, ld_status, saved_valid, fault});
        end
    endtask

    task automatic test_priority();
        status = status_t'(6'b0);
        irq = 1'b1;
        swi = 1'b1;
        ready = 1'b1;
        cyc();
        swi = 1'b0;
        cyc();
        status = status_t'(6'b000011);
        cyc();
        vectors++;
        if ({vector_req, cause} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL swi_over_irq: got %b expected 110", {vector_req, cause});
        end
        irq = 1'b0;
        cyc();
        rti = 1'b1;
        cyc();
        rti = 1'b0;
        status = status_t'(6'b0);
        cyc();
        status = status_t'(6'b000010);
        irq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            vectors++;
            if ({busy, vector_req, fault, saved_valid} !== 4'b0) begin
                miscompares++;
                $display("[TB] FAIL masked_irq cycle %0d: got %b expected 0000",
                         i, {busy, vector_req, fault, saved_valid});
            end
        end
        irq = 1'b0;
        cyc();
    endtask

    task automatic test_faults();
        rti = 1'b1;
        cyc();
        rti = 1'b0;
        vectors++;
        if ({fault, ld_status, busy} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL rti_no_frame: got %b expected 100", {fault, ld_status, busy});
        end
        cyc();
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fault_one_cycle: got %b expected 0", fault);
        end
        status = status_t'(6'b110100);
        swi = 1'b1;
        cyc();
        swi = 1'b0;
        cyc();
        status = status_t'(6'b110111);
        cyc();
        cyc();
        vectors++;
        if ({saved_valid, busy, saved_status} !== 8'b10_110100) begin
            miscompares++;
            $display("[TB] FAIL swi_frame: got %b expected 10110100", {saved_valid, busy, saved_status});
        end
        status = status_t'(6'b110110);
        rti = 1'b1;
        cyc();
        rti = 1'b0;
        vectors++;
        if ({fault, saved_valid, busy, ld_status} !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL rti_user: got %b expected 1100", {fault, saved_valid, busy, ld_status});
        end
        swi = 1'b1;
        cyc();
        swi = 1'b0;
        vectors++;
        if ({fault, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL swi_nested: got %b expected 10", {fault, busy});
        end
        cyc();
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL swi_fault_len: got %b expected 0", fault);
        end
        status = status_t'(6'b110111);
        rti = 1'b1;
        swi = 1'b1;
        cyc();
        rti = 1'b0;
        swi = 1'b0;
        vectors++;
        if ({busy, ld_status, fault, ld_mode, status_out} !== 10'b1100_110100) begin
            miscompares++;
            $display("[TB] FAIL rti_swi_same: got %b expected 1100110100",
                     {busy, ld_status, fault, ld_mode, status_out});
        end
        status = status_t'(6'b110100);
        cyc();
        vectors++;
        if ({busy, saved_valid, fault} !== 3'b0) begin
            miscompares++;
            $display("[TB] FAIL rti_swi_after: got %b expected 000", {busy, saved_valid, fault});
        end
    endtask

    task automatic test_reset_mid();
        status = status_t'(6'b0);
        irq = 1'b1;
        ready = 1'b1;
        cyc();
        cyc();
        vectors++;
        if (ld_mode !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_enter: got %b expected 1", ld_mode);
        end
        irq = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, vector_req, ld_mode, ld_imask, ld_status, fault, saved_valid, cause} !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got %b expected 0",
                     {busy, vector_req, ld_mode, ld_imask, ld_status, fault, saved_valid, cause});
        end
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if ({busy, vector_req} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL no_resume cycle %0d: got %b expected 00", i, {busy, vector_req});
            end
        end
        irq = 1'b1;
        cyc();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL first_after_reset: got %b expected 1", busy);
        end
        cyc();
        status = status_t'(6'b000011);
        cyc();
        vectors++;
        if ({vector_req, cause} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL post_reset_ack: got %b expected 101", {vector_req, cause});
        end
        irq = 1'b0;
        cyc();
    endtask

    typedef struct packed {
        logic       busy;
        logic       ld_mode;
        logic       vector_req;
        logic       ld_status;
        logic [1:0] cause;
        logic       capture;
        logic       enter;
        logic       restore;
    } exp_t;

    // Model: each accepted request queues one expected-output record per busy cycle.
    task automatic test_random();
        exp_t    q[$];
        exp_t    e;
        status_t m_saved;
        status_t st_next;
        logic    m_valid;
        logic    m_fault;

        rst = 1'b1;
        idle_inputs();
        status = status_t'(6'b0);
        cyc();
        rst = 1'b0;
        m_saved = status_t'(6'b0);
        m_valid = 1'b0;
        m_fault = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (q.size() == 0 && $urandom_range(0, 15) == 0)
                status = status_t'(6'($urandom_range(0, 63)));
            e = (q.size() != 0) ? q[0] : exp_t'(0);

            vectors++;
            if ({busy, ld_mode, ld_imask, vector_req, ld_status} !==
                {e.busy, e.ld_mode, e.ld_mode, e.vector_req, e.ld_status}) begin
                miscompares++;
                $display("[TB] FAIL rand_strobes @%0d: got %b expected %b", n,
                         {busy, ld_mode, ld_imask, vector_req, ld_status},
                         {e.busy, e.ld_mode, e.ld_mode, e.vector_req, e.ld_status});
            end
            vectors++;
            if (status_out !== (e.ld_status ? 6'(m_saved) : 6'b0)) begin
                miscompares++;
                $display("[TB] FAIL rand_status_out @%0d: got %b expected %b", n,
                         status_out, (e.ld_status ? 6'(m_saved) : 6'b0));
            end
            vectors++;
            if (fault !== m_fault) begin
                miscompares++;
                $display("[TB] FAIL rand_fault @%0d: got %b expected %b", n, fault, m_fault);
            end
            vectors++;
            if ({saved_valid, saved_status} !== {m_valid, m_saved}) begin
                miscompares++;
                $display("[TB] FAIL rand_shadow @%0d: got %b expected %b", n,
                         {saved_valid, saved_status}, {m_valid, m_saved});
            end
            if (e.vector_req || !e.busy) begin
                vectors++;
                if (cause !== e.cause) begin
                    miscompares++;
                    $display("[TB] FAIL rand_cause @%0d: got %b expected %b", n, cause, e.cause);
                end
            end

            if ($urandom_range(0, 3) == 0) irq = ~irq;
            swi   = ($urandom_range(0, 7) == 0);
            rti   = ($urandom_range(0, 5) == 0);
            ready = ($urandom_range(0, 3) != 0);

            m_fault = 1'b0;
            st_next = status;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.capture) begin
                    m_saved = status;
                    m_valid = 1'b1;
                end
                if (e.enter) begin
                    st_next.mode  = SUPERVISOR;
                    st_next.imask = 1'b1;
                end
                if (e.restore) begin
                    st_next = m_saved;
                    m_valid = 1'b0;
                end
            end else if (rti) begin
                if (m_valid && status.mode == SUPERVISOR) begin
                    e = '0; e.busy = 1'b1; e.ld_status = 1'b1; e.restore = 1'b1;
                    q.push_back(e);
                end else begin
                    m_fault = 1'b1;
                end
            end else if (swi && m_valid) begin
                m_fault = 1'b1;
            end else if (ready && !m_valid && (swi || (irq && !status.imask))) begin
                e = '0; e.busy = 1'b1; e.capture = 1'b1;
                q.push_back(e);
                e = '0; e.busy = 1'b1; e.ld_mode = 1'b1; e.enter = 1'b1;
                q.push_back(e);
                e = '0; e.busy = 1'b1; e.vector_req = 1'b1; e.cause = swi ? 2'b10 : 2'b01;
                q.push_back(e);
            end
            cyc();
            status = st_next;
        end
    endtask

    initial begin
        test_reset();
        test_irq_entry();
        test_rti_restore();
        test_priority();
        test_faults();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
